fetch_queue_unit: RTL and testbench

Parametrised successor to the single-register fetch stage. Owns the PC, drives the combinational instruction memory address, and buffers fetched {pc, instruction} pairs in a DEPTH-entry FIFO. Decode consumes the FIFO through a valid/ready handshake. Execute can redirect the stream; a redirect flushes the queue. Sits between the PC/instruction memory and the decode stage.

---
 rtl/fetch_queue_unit.sv | 134 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Fetch stage with a DEPTH-entry {pc, instruction} queue feeding decode over valid/ready.
// Define FETCH_PERF_EN to build the fetched/stall performance counters; otherwise they read 0.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_en,
    output logic [XLEN-1:0]          imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_stalls
);

    localparam int unsigned     AW         = $clog2(DEPTH);
    localparam int unsigned     CW         = AW + 1;
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

    logic [XLEN-1:0] pc_q, pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full, pop, push;

    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [XLEN-1:0] mem_instr_q [DEPTH];

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        pop      = (count_q != '0) && out_ready;
        push     = fetch_en && !redirect_valid && (!full || pop);
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect_valid) begin
            // The head is discarded, so a same-cycle pop has no effect.
            pc_d     = redirect_target & ALIGN_MASK;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + STEP;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = mem_pc_q[rd_ptr_q];
    assign out_instr = mem_instr_q[rd_ptr_q];
    assign count     = count_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic        stall;

    always_comb begin
        stall          = fetch_en && !redirect_valid && full && !pop;
        perf_fetched_d = perf_fetched_q;
        perf_stalls_d  = perf_stalls_q;
        if (push) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (stall) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalls  = perf_stalls_q;
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: queue scoreboard on the default instance
// plus directed checks, and a second instance with RESET_PC near the top of the address space.
module tb_fetch_queue_unit;

    localparam int CW = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_en;
    logic          redirect_valid;
    logic [31:0]   redirect_target;
    logic          out_ready;

    logic [31:0]   imem_addr, imem_rdata, out_instr, out_pc, perf_fetched, perf_stalls;
    logic          out_valid;
    logic [CW-1:0] count;

    logic [31:0]   w_imem_addr, w_imem_rdata, w_out_instr, w_out_pc, w_perf_fetched, w_perf_stalls;
    logic          w_out_valid;
    logic [CW-1:0] w_count;

    entry_t        sb[$];
    logic [31:0]   m_pc;
    logic [31:0]   m_fetched;
    logic [31:0]   m_stalls;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = imem_addr ^ 32'hA5A5_0000;
    assign w_imem_rdata = w_imem_addr ^ 32'hA5A5_0000;

    fetch_queue_unit dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .count(count),
        .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
    );

    fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .count(w_count),
        .perf_fetched(w_perf_fetched), .perf_stalls(w_perf_stalls)
    );

    // Called at a negedge with inputs already driven: compares the main instance
    // against the queue model, advances the model, then moves to the next negedge.
    task automatic tick();
        entry_t e;
        bit     full, pop, push;
        n_checks++;
        if (out_valid !== (sb.size() != 0)) $display("FAIL sb_valid: got %b expected %b", out_valid, sb.size() != 0);
        else n_pass++;
        n_checks++;
        if (count !== CW'(sb.size())) $display("FAIL sb_count: got %0d expected %0d", count, sb.size());
        else n_pass++;
        n_checks++;
        if (imem_addr !== m_pc) $display("FAIL sb_imem_addr: got %h expected %h", imem_addr, m_pc);
        else n_pass++;
        n_checks++;
        if (perf_fetched !== m_fetched) $display("FAIL sb_perf_fetched: got %0d expected %0d", perf_fetched, m_fetched);
        else n_pass++;
        n_checks++;
        if (perf_stalls !== m_stalls) $display("FAIL sb_perf_stalls: got %0d expected %0d", perf_stalls, m_stalls);
        else n_pass++;

        full = (sb.size() == 4);
        pop  = (sb.size() != 0) && out_ready;
        if (reset) begin
            sb.delete();
            m_pc      = 32'h0;
            m_fetched = 32'h0;
            m_stalls  = 32'h0;
        end else if (redirect_valid) begin
            sb.delete();
            m_pc = redirect_target & ~32'h3;
        end else begin
            if (pop) begin
                e = sb.pop_front();
                n_checks++;
                if (out_pc !== e.pc) $display("FAIL sb_pop_pc: got %h expected %h", out_pc, e.pc);
                else n_pass++;
                n_checks++;
                if (out_instr !== e.instr) $display("FAIL sb_pop_instr: got %h expected %h", out_instr, e.instr);
                else n_pass++;
            end
            push = fetch_en && (!full || pop);
            if (push) begin
                e.pc    = m_pc;
                e.instr = m_pc ^ 32'hA5A5_0000;
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
`ifdef FETCH_PERF_EN
                m_fetched = m_fetched + 32'd1;
`endif
            end
`ifdef FETCH_PERF_EN
            if (fetch_en && full && !pop) m_stalls = m_stalls + 32'd1;
`endif
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (out_valid !== 1'b0 || count !== '0) $display("FAIL reset_empty: got valid=%b count=%0d expected 0/0", out_valid, count);
        else n_pass++;
        n_checks++;
        if (imem_addr !== 32'h0) $display("FAIL reset_pc: got %h expected 00000000", imem_addr);
        else n_pass++;
        n_checks++;
        if (w_imem_addr !== 32'hFFFF_FFF8) $display("FAIL reset_pc_wrap: got %h expected fffffff8", w_imem_addr);
        else n_pass++;
    endtask

    task automatic test_sequential();
        reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_pc !== 32'(i * 4) || count !== CW'(1))
                $display("FAIL seq_head%0d: got pc=%h count=%0d expected pc=%h count=1", i, out_pc, count, 32'(i * 4));
            else n_pass++;
            n_checks++;
            if (out_instr !== (32'(i * 4) ^ 32'hA5A5_0000))
                $display("FAIL seq_instr%0d: got %h expected %h", i, out_instr, 32'(i * 4) ^ 32'hA5A5_0000);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_fill_stall();
        reset = 1'b1; tick();
        reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (count !== CW'(i)) $display("FAIL fill_count%0d: got %0d expected %0d", i, count, i);
            else n_pass++;
        end
        tick(); tick(); tick();
        n_checks++;
        if (count !== CW'(4) || imem_addr !== 32'd16)
            $display("FAIL full_hold: got count=%0d addr=%h expected 4/00000010", count, imem_addr);
        else n_pass++;
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_stalls !== 32'd3 || perf_fetched !== 32'd4)
            $display("FAIL perf_counts: got stalls=%0d fetched=%0d expected 3/4", perf_stalls, perf_fetched);
        else n_pass++;
`else
        n_checks++;
        if (perf_stalls !== 32'd0 || perf_fetched !== 32'd0)
            $display("FAIL perf_tied: got stalls=%0d fetched=%0d expected 0/0", perf_stalls, perf_fetched);
        else n_pass++;
`endif
    endtask

    task automatic test_full_pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_pc !== 32'd4 || count !== CW'(4) || imem_addr !== 32'd20)
            $display("FAIL full_pop: got pc=%h count=%0d addr=%h expected 00000004/4/00000014", out_pc, count, imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect();
        reset = 1'b1; tick();
        reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (count !== CW'(3)) $display("FAIL redir_pre_count: got %0d expected 3", count);
        else n_pass++;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== '0 || imem_addr !== 32'h100)
            $display("FAIL redir_flush: got valid=%b count=%0d addr=%h expected 0/0/00000100", out_valid, count, imem_addr);
        else n_pass++;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'hA5A5_0100)
            $display("FAIL redir_first: got valid=%b pc=%h instr=%h expected 1/00000100/a5a50100", out_valid, out_pc, out_instr);
        else n_pass++;
    endtask

    task automatic test_redirect_pop_hold();
        tick();
        redirect_valid = 1'b1; redirect_target = 32'h0000_2002; out_ready = 1'b1; fetch_en = 1'b0;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== '0 || imem_addr !== 32'h2000)
            $display("FAIL redir_pop: got valid=%b count=%0d addr=%h expected 0/0/00002000", out_valid, count, imem_addr);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if (imem_addr !== 32'h2000 || count !== '0)
            $display("FAIL hold_empty: got addr=%h count=%0d expected 00002000/0", imem_addr, count);
        else n_pass++;
    endtask

    task automatic test_wrap_midreset();
        reset = 1'b1; tick();
        reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick();
        fetch_en = 1'b0;
        n_checks++;
        if (w_out_pc !== 32'hFFFF_FFF8 || w_out_instr !== 32'h5A5A_FFF8 || w_count !== CW'(2))
            $display("FAIL wrap_head: got pc=%h instr=%h count=%0d expected fffffff8/5a5afff8/2", w_out_pc, w_out_instr, w_count);
        else n_pass++;
        n_checks++;
        if (w_imem_addr !== 32'h0) $display("FAIL wrap_pc: got %h expected 00000000", w_imem_addr);
        else n_pass++;
        reset = 1'b1; tick();
        reset = 1'b0;
        n_checks++;
        if (w_out_valid !== 1'b0 || w_count !== '0 || w_imem_addr !== 32'hFFFF_FFF8)
            $display("FAIL midreset: got valid=%b count=%0d addr=%h expected 0/0/fffffff8", w_out_valid, w_count, w_imem_addr);
        else n_pass++;
        fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        n_checks++;
        if (w_out_pc !== 32'hFFFF_FFF8) $display("FAIL wrap_seq0: got %h expected fffffff8", w_out_pc);
        else n_pass++;
        tick();
        n_checks++;
        if (w_out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_seq1: got %h expected fffffffc", w_out_pc);
        else n_pass++;
        tick();
        n_checks++;
        if (w_out_pc !== 32'h0 || w_count !== CW'(1)) $display("FAIL wrap_seq2: got pc=%h count=%0d expected 00000000/1", w_out_pc, w_count);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_pc = 32'h0; m_fetched = 32'h0; m_stalls = 32'h0;
        sb.delete();

        test_reset();
        test_sequential();
        test_fill_stall();
        test_full_pop();
        test_redirect();
        test_redirect_pop_hold();
        test_wrap_midreset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
